wb_regfile: RTL and testbench



---
 rtl/wb_regfile.sv | 64 ++++++
 tb/tb_wb_regfile.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// Write-back stage and architectural GPR file: result select, commit to the
// 2^ADDR_W-entry array, two bypassed decode read ports, one raw debug port.
module wb_regfile #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int BYPASS  = 1,
  parameter int COUNT_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               RegWriteW,
  input  logic               MemtoRegW,
  input  logic [DATA_W-1:0]  ALUOutW,
  input  logic [DATA_W-1:0]  ReadDataW,
  input  logic [ADDR_W-1:0]  WriteRegW,
  output logic [DATA_W-1:0]  ResultW,
  input  logic [ADDR_W-1:0]  A1,
  input  logic [ADDR_W-1:0]  A2,
  output logic [DATA_W-1:0]  RD1,
  output logic [DATA_W-1:0]  RD2,
  input  logic [ADDR_W-1:0]  DbgAddr,
  output logic [DATA_W-1:0]  DbgData,
  output logic [COUNT_W-1:0] WbCount
);

  localparam int NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [NREG];
  logic              commit;
  logic              byp1;
  logic              byp2;

  assign ResultW = MemtoRegW ? ReadDataW : ALUOutW;

  // Writes to $0 are dropped entirely, so they neither commit nor bypass.
  assign commit = !rst && RegWriteW && (WriteRegW != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
      WbCount <= '0;
    end else if (commit) begin
      regs[WriteRegW] <= ResultW;
      WbCount         <= WbCount + COUNT_W'(1);
    end
  end

  assign byp1 = (BYPASS != 0) && commit && (A1 == WriteRegW);
  assign byp2 = (BYPASS != 0) && commit && (A2 == WriteRegW);

  always_comb begin
    RD1 = regs[A1];
    RD2 = regs[A2];
    if (byp1) RD1 = ResultW;
    if (byp2) RD2 = ResultW;
    if (A1 == '0) RD1 = '0;
    if (A2 == '0) RD2 = '0;
  end

  assign DbgData = (DbgAddr == '0) ? '0 : regs[DbgAddr];

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: three builds (default, 4-bit counter, no bypass) share
// one stimulus stream and are checked every cycle against an array model.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteW, MemtoRegW;
  logic [31:0] ALUOutW, ReadDataW;
  logic [4:0]  WriteRegW, A1, A2, DbgAddr;

  logic [31:0] resA, rd1A, rd2A, dbgA, cntA;
  logic [31:0] resC, rd1C, rd2C, dbgC;
  logic [3:0]  cntC;
  logic [31:0] resN, rd1N, rd2N, dbgN, cntN;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk(clk), .rst(rst), .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW),
    .ALUOutW(ALUOutW), .ReadDataW(ReadDataW), .WriteRegW(WriteRegW),
    .ResultW(resA), .A1(A1), .A2(A2), .RD1(rd1A), .RD2(rd2A),
    .DbgAddr(DbgAddr), .DbgData(dbgA), .WbCount(cntA));

  wb_regfile #(.COUNT_W(4)) dutC (
    .clk(clk), .rst(rst), .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW),
    .ALUOutW(ALUOutW), .ReadDataW(ReadDataW), .WriteRegW(WriteRegW),
    .ResultW(resC), .A1(A1), .A2(A2), .RD1(rd1C), .RD2(rd2C),
    .DbgAddr(DbgAddr), .DbgData(dbgC), .WbCount(cntC));

  wb_regfile #(.BYPASS(0)) dutN (
    .clk(clk), .rst(rst), .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW),
    .ALUOutW(ALUOutW), .ReadDataW(ReadDataW), .WriteRegW(WriteRegW),
    .ResultW(resN), .A1(A1), .A2(A2), .RD1(rd1N), .RD2(rd2N),
    .DbgAddr(DbgAddr), .DbgData(dbgN), .WbCount(cntN));

  // Reference model: plain array plus a commit tally.
  logic [31:0] mdl [32];
  int unsigned tally = 0;
  bit          seenReset = 0;

  always @(posedge clk) begin
    if (rst) begin
      foreach (mdl[i]) mdl[i] = 32'h0;
      tally = 0;
      seenReset = 1;
    end else if (RegWriteW && WriteRegW != 5'd0) begin
      mdl[WriteRegW] = MemtoRegW ? ReadDataW : ALUOutW;
      tally = tally + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] expRd(input logic [4:0] a, input bit byp);
    logic [31:0] sel;
    sel = MemtoRegW ? ReadDataW : ALUOutW;
    if (a == 5'd0) return 32'h0;
    if (byp && !rst && RegWriteW && WriteRegW == a) return sel;
    return mdl[a];
  endfunction

  always @(negedge clk) begin
    if (seenReset) begin
      logic [31:0] sel;
      sel = MemtoRegW ? ReadDataW : ALUOutW;
      chk("resA", resA, sel);
      chk("rd1A", rd1A, expRd(A1, 1));
      chk("rd2A", rd2A, expRd(A2, 1));
      chk("dbgA", dbgA, mdl[DbgAddr]);
      chk("cntA", cntA, tally);
      chk("resC", resC, sel);
      chk("rd1C", rd1C, expRd(A1, 1));
      chk("dbgC", dbgC, mdl[DbgAddr]);
      chk("cntC", 32'(cntC), tally % 16);
      chk("rd1N", rd1N, expRd(A1, 0));
      chk("rd2N", rd2N, expRd(A2, 0));
      chk("dbgN", dbgN, mdl[DbgAddr]);
      chk("cntN", cntN, tally);
    end
  end

  task automatic drive(input bit r, input bit rw, input bit m2r, input logic [31:0] alu,
                       input logic [31:0] rd, input logic [4:0] wr, input logic [4:0] a1,
                       input logic [4:0] a2, input logic [4:0] dbg);
    @(posedge clk);
    #1;
    rst = r; RegWriteW = rw; MemtoRegW = m2r; ALUOutW = alu; ReadDataW = rd;
    WriteRegW = wr; A1 = a1; A2 = a2; DbgAddr = dbg;
    @(negedge clk);
  endtask

  function automatic logic [31:0] pat(input int i);
    return 32'h0101_0101 * i ^ 32'hA5A5_0000;
  endfunction

  initial begin
    rst = 1; RegWriteW = 0; MemtoRegW = 0; ALUOutW = 0; ReadDataW = 0;
    WriteRegW = 0; A1 = 0; A2 = 0; DbgAddr = 0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    chk("reset_cnt", cntA, 32'h0);
    chk("reset_rd1", rd1A, 32'h0);

    // Reset then write reg 5.
    drive(0, 1, 0, 32'h1234_5678, 32'h0, 5'd5, 5'd0, 5'd0, 5'd0);
    drive(0, 0, 0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd0, 5'd5);
    chk("t1_rd1", rd1A, 32'h1234_5678);
    chk("t1_dbg", dbgA, 32'h1234_5678);
    chk("t1_cnt", cntA, 32'd1);

    // Load select with same-cycle bypass on both ports.
    drive(0, 1, 1, 32'h1, 32'hDEAD_BEEF, 5'd7, 5'd7, 5'd7, 5'd7);
    chk("t2_res", resA, 32'hDEAD_BEEF);
    chk("t2_rd1", rd1A, 32'hDEAD_BEEF);
    chk("t2_rd2", rd2A, 32'hDEAD_BEEF);
    chk("t2_dbg_old", dbgA, 32'h0);
    chk("t2_nobyp", rd1N, 32'h0);
    drive(0, 0, 0, 32'h0, 32'h0, 5'd0, 5'd7, 5'd0, 5'd7);
    chk("t2_dbg_new", dbgA, 32'hDEAD_BEEF);
    chk("t2_nobyp_after", rd1N, 32'hDEAD_BEEF);
    chk("t2_cnt", cntA, 32'd2);

    // $0 protection.
    drive(0, 1, 0, 32'hFFFF_FFFF, 32'h0, 5'd0, 5'd0, 5'd0, 5'd0);
    chk("t3_rd1_pre", rd1A, 32'h0);
    drive(0, 0, 0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 5'd0);
    chk("t3_rd1_post", rd1A, 32'h0);
    chk("t3_dbg0", dbgA, 32'h0);
    chk("t3_cnt", cntA, 32'd2);

    // RegWriteW low: no write, no bypass.
    drive(0, 0, 0, 32'hAA, 32'h0, 5'd9, 5'd9, 5'd0, 5'd9);
    chk("t4_rd1", rd1A, 32'h0);
    drive(0, 0, 0, 32'h0, 32'h0, 5'd0, 5'd9, 5'd0, 5'd9);
    chk("t4_dbg", dbgA, 32'h0);
    chk("t4_cnt", cntA, 32'd2);

    // Reset coincident with a write.
    drive(1, 1, 0, 32'h55, 32'h0, 5'd3, 5'd3, 5'd7, 5'd3);
    chk("t5_rd1_rst", rd1A, 32'h0);
    chk("t5_rd2_rst", rd2A, 32'hDEAD_BEEF);
    drive(0, 0, 0, 32'h0, 32'h0, 5'd0, 5'd7, 5'd0, 5'd3);
    chk("t5_dbg3", dbgA, 32'h0);
    chk("t5_rd1_7", rd1A, 32'h0);
    chk("t5_cnt", cntA, 32'd0);
    drive(0, 1, 0, 32'h33, 32'h0, 5'd3, 5'd0, 5'd0, 5'd3);
    drive(0, 0, 0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 5'd3);
    chk("t5_dbg3_new", dbgA, 32'h33);
    chk("t5_cnt1", cntA, 32'd1);

    // Counter wrap on the 4-bit build: 17 commits after a fresh reset.
    drive(1, 0, 0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 5'd0);
    for (int i = 1; i <= 17; i++)
      drive(0, 1, i[0], pat(i), pat(i), 5'(i), 5'd0, 5'd0, 5'd0);
    drive(0, 0, 0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 5'd0);
    chk("t6_cntC", 32'(cntC), 32'd1);
    chk("t6_cntA", cntA, 32'd17);
    for (int i = 1; i <= 17; i++) begin
      drive(0, 0, 0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 5'(i));
      chk("t6_dbgC", dbgC, pat(i));
    end

    // Randomized phase; the negedge process compares against the model.
    for (int n = 0; n < 2000; n++) begin
      logic [4:0] wr, a1, a2;
      wr = 5'($urandom_range(0, 31));
      a1 = ($urandom_range(0, 2) == 0) ? wr : 5'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 2) == 0) ? wr : 5'($urandom_range(0, 31));
      drive($urandom_range(0, 60) == 0, $urandom_range(0, 3) != 0, 1'($urandom),
            $urandom, $urandom, wr, a1, a2, 5'($urandom_range(0, 31)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
